// File: rtl/param_memory.sv
// param_memory: parametrised single-port synchronous RAM with a registered
// read port, a hardware clear sweep (after reset and on request), a busy flag
// and out-of-range address detection.
//
// Output strobes: data_valid is a one-cycle pulse meaning data_bus_out was
// loaded by a read on the previous rising edge; it carries no backpressure
// (there is no ready), so a consumer must capture data_bus_out in that cycle.
// addr_err is a one-cycle pulse for an accepted access with address_bus >= DEPTH.
// busy is high while the clear sweep owns the array; accesses are ignored then.
module param_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_enable,
    input  logic                  read_write,
    input  logic [ADDR_WIDTH-1:0] address_bus,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_bus_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  addr_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // State entered on reset: sweep first, or straight to normal operation.
    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;
    // Last word written by the sweep.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // Depth widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_en;
    logic                  err_next;

    // Unsigned compare over the full address width.
    assign in_range = ({1'b0, address_bus} < DEPTH_W);

    // busy is the registered state itself, so it has no input-to-output path.
    assign busy = (state == CLEAR);

    // Next-state, sweep counter and array-port decode for the current cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_we     = 1'b0;
        mem_waddr  = address_bus;
        mem_wdata  = data_bus_in;
        rd_en      = 1'b0;
        err_next   = 1'b0;
        case (state)
            CLEAR: begin
                // Sweep owns the array; mem_enable and clear are ignored.
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                if (cnt == LAST_ADDR) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                if (clear) begin
                    // A clear request wins and drops any simultaneous access.
                    state_next = CLEAR;
                end else if (mem_enable) begin
                    if (!in_range) begin
                        err_next = 1'b1;
                    end else if (read_write) begin
                        rd_en = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
        endcase
    end

    // Control state, sweep counter and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RESET_STATE;
            cnt          <= '0;
            data_bus_out <= '0;
            data_valid   <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            data_valid <= rd_en;
            addr_err   <= err_next;
            if (rd_en) begin
                data_bus_out <= mem[address_bus];
            end
        end
    end

    // Array write port; contents survive reset, so writes are only blocked while in reset.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: three parameterisations of param_memory (defaults, DEPTH=12,
// 16-bit x 64 without init clear) exercised by per-scenario tasks.
module tb_param_memory;

    logic clk;
    logic rst_n;

    // Default instance: 8 x 16, INIT_CLEAR = 1
    logic       en8, rw8, clr8;
    logic [3:0] a8;
    logic [7:0] d8;
    logic [7:0] out8;
    logic       dv8, busy8, err8;

    // DEPTH = 12 instance
    logic       en12, rw12, clr12;
    logic [3:0] a12;
    logic [7:0] d12;
    logic [7:0] out12;
    logic       dv12, busy12, err12;

    // 16 x 64 instance, INIT_CLEAR = 0
    logic        en16, rw16, clr16;
    logic [5:0]  a16;
    logic [15:0] d16;
    logic [15:0] out16;
    logic        dv16, busy16, err16;

    logic [7:0]  exp_q[$];
    logic [15:0] exp16_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    param_memory u_dut (
        .clk(clk), .rst_n(rst_n), .mem_enable(en8), .read_write(rw8),
        .address_bus(a8), .data_bus_in(d8), .clear(clr8),
        .data_bus_out(out8), .data_valid(dv8), .busy(busy8), .addr_err(err8)
    );

    param_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .INIT_CLEAR(1)) u_d12 (
        .clk(clk), .rst_n(rst_n), .mem_enable(en12), .read_write(rw12),
        .address_bus(a12), .data_bus_in(d12), .clear(clr12),
        .data_bus_out(out12), .data_valid(dv12), .busy(busy12), .addr_err(err12)
    );

    param_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .DEPTH(64), .INIT_CLEAR(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .mem_enable(en16), .read_write(rw16),
        .address_bus(a16), .data_bus_in(d16), .clear(clr16),
        .data_bus_out(out16), .data_valid(dv16), .busy(busy16), .addr_err(err16)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        int c8, c12, c16, bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (out8 !== 8'h00 || dv8 !== 1'b0 || err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: out=%h valid=%b err=%b, expected 00 0 0", out8, dv8, err8);
        end
        n_vec++;
        if (busy8 !== 1'b1 || busy12 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_init: busy8=%b busy12=%b, expected 1 1", busy8, busy12);
        end
        n_vec++;
        if (busy16 !== 1'b0 || out16 !== 16'h0000 || dv16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_noinit: busy=%b out=%h valid=%b, expected 0 0000 0", busy16, out16, dv16);
        end
        rst_n = 1'b1;
        c8 = 0; c12 = 0; c16 = 0; bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (busy8 === 1'b1) c8++;
            if (busy12 === 1'b1) c12++;
            if (busy16 === 1'b1) c16++;
            if (dv8 !== 1'b0 || err8 !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (c8 != 16) begin
            n_fail++;
            $display("FAIL sweep_len_16: busy cycles=%0d, expected 16", c8);
        end
        n_vec++;
        if (c12 != 12) begin
            n_fail++;
            $display("FAIL sweep_len_12: busy cycles=%0d, expected 12", c12);
        end
        n_vec++;
        if (c16 != 0) begin
            n_fail++;
            $display("FAIL sweep_noinit: busy cycles=%0d, expected 0", c16);
        end
        n_vec++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sweep_quiet: strobe cycles=%0d, expected 0", bad);
        end
    endtask

    task automatic test_first_read();
        logic [7:0] exp;
        en8 = 1'b1; rw8 = 1'b1; a8 = 4'd5;
        exp_q.push_back(8'h00);
        @(negedge clk);
        en8 = 1'b0;
        exp = exp_q.pop_front();
        n_vec++;
        if (dv8 !== 1'b1 || out8 !== exp) begin
            n_fail++;
            $display("FAIL first_read: valid=%b out=%h, expected 1 %h", dv8, out8, exp);
        end
        @(negedge clk);
        n_vec++;
        if (dv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL first_read_pulse: valid=%b, expected 0", dv8);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] exp;
        en8 = 1'b1; rw8 = 1'b0; a8 = 4'd5; d8 = 8'h0F;
        @(negedge clk);
        rw8 = 1'b1;
        exp_q.push_back(8'h0F);
        n_vec++;
        if (dv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_valid: valid=%b, expected 0", dv8);
        end
        @(negedge clk);
        en8 = 1'b0;
        exp = exp_q.pop_front();
        n_vec++;
        if (dv8 !== 1'b1 || out8 !== exp) begin
            n_fail++;
            $display("FAIL write_then_read: valid=%b out=%h, expected 1 %h", dv8, out8, exp);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (dv8 !== 1'b0 || out8 !== 8'h0F) begin
            n_fail++;
            $display("FAIL read_hold: valid=%b out=%h, expected 0 0f", dv8, out8);
        end
    endtask

    task automatic test_clear();
        int c;
        logic [7:0] exp;
        en8 = 1'b1; rw8 = 1'b0; a8 = 4'd3; d8 = 8'hA5;
        @(negedge clk);
        clr8 = 1'b1; a8 = 4'd4; d8 = 8'h77;
        @(negedge clk);
        clr8 = 1'b0; en8 = 1'b0;
        c = 0;
        for (int i = 0; i < 24; i++) begin
            if (busy8 === 1'b1) c++;
            if (i == 7) begin
                // Mid-sweep clear and write must both be ignored.
                clr8 = 1'b1; en8 = 1'b1; rw8 = 1'b0; a8 = 4'd3; d8 = 8'h55;
            end else begin
                clr8 = 1'b0; en8 = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++;
        if (c != 16) begin
            n_fail++;
            $display("FAIL clear_sweep_len: busy cycles=%0d, expected 16", c);
        end
        en8 = 1'b1; rw8 = 1'b1; a8 = 4'd3;
        exp_q.push_back(8'h00);
        @(negedge clk);
        a8 = 4'd4;
        exp_q.push_back(8'h00);
        exp = exp_q.pop_front();
        n_vec++;
        if (dv8 !== 1'b1 || out8 !== exp) begin
            n_fail++;
            $display("FAIL clear_addr3: valid=%b out=%h, expected 1 %h", dv8, out8, exp);
        end
        @(negedge clk);
        en8 = 1'b0;
        exp = exp_q.pop_front();
        n_vec++;
        if (dv8 !== 1'b1 || out8 !== exp) begin
            n_fail++;
            $display("FAIL clear_addr4_dropped: valid=%b out=%h, expected 1 %h", dv8, out8, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_addr_err();
        logic [7:0] exp;
        en12 = 1'b1; rw12 = 1'b0; a12 = 4'd11; d12 = 8'h3C;
        @(negedge clk);
        rw12 = 1'b1;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        a12 = 4'd12;
        exp = exp_q.pop_front();
        n_vec++;
        if (dv12 !== 1'b1 || out12 !== exp || err12 !== 1'b0) begin
            n_fail++;
            $display("FAIL d12_read11: valid=%b out=%h err=%b, expected 1 %h 0", dv12, out12, err12, exp);
        end
        @(negedge clk);
        rw12 = 1'b0; a12 = 4'd15; d12 = 8'hFF;
        n_vec++;
        if (err12 !== 1'b1 || dv12 !== 1'b0 || out12 !== 8'h3C) begin
            n_fail++;
            $display("FAIL d12_read12_err: err=%b valid=%b out=%h, expected 1 0 3c", err12, dv12, out12);
        end
        @(negedge clk);
        rw12 = 1'b1; a12 = 4'd11;
        exp_q.push_back(8'h3C);
        n_vec++;
        if (err12 !== 1'b1 || dv12 !== 1'b0 || out12 !== 8'h3C) begin
            n_fail++;
            $display("FAIL d12_write15_err: err=%b valid=%b out=%h, expected 1 0 3c", err12, dv12, out12);
        end
        @(negedge clk);
        en12 = 1'b0;
        exp = exp_q.pop_front();
        n_vec++;
        if (dv12 !== 1'b1 || out12 !== exp || err12 !== 1'b0) begin
            n_fail++;
            $display("FAIL d12_reread11: valid=%b out=%h err=%b, expected 1 %h 0", dv12, out12, err12, exp);
        end
        // Full-depth instance: highest address is legal.
        en8 = 1'b1; rw8 = 1'b1; a8 = 4'd15;
        exp_q.push_back(8'h00);
        @(negedge clk);
        en8 = 1'b0;
        exp = exp_q.pop_front();
        n_vec++;
        if (dv8 !== 1'b1 || out8 !== exp || err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL full_depth_addr15: valid=%b out=%h err=%b, expected 1 %h 0", dv8, out8, err8, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        int c;
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_busy: busy=%b, expected 1", busy8);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        for (int i = 0; i < 24; i++) begin
            if (busy8 === 1'b1) c++;
            @(negedge clk);
        end
        n_vec++;
        if (c != 16) begin
            n_fail++;
            $display("FAIL restart_sweep_len: busy cycles=%0d, expected 16", c);
        end
    endtask

    task automatic test_wide();
        logic [15:0] exp;
        int bb;
        bb = 0;
        en16 = 1'b1; rw16 = 1'b0; a16 = 6'd0; d16 = 16'hBEEF;
        @(negedge clk);
        if (busy16 !== 1'b0) bb++;
        a16 = 6'd63; d16 = 16'h1234;
        @(negedge clk);
        if (busy16 !== 1'b0) bb++;
        a16 = 6'd62; d16 = 16'hFFFF;
        @(negedge clk);
        if (busy16 !== 1'b0) bb++;
        rw16 = 1'b1; a16 = 6'd0;
        exp16_q.push_back(16'hBEEF);
        @(negedge clk);
        a16 = 6'd63;
        exp16_q.push_back(16'h1234);
        exp = exp16_q.pop_front();
        n_vec++;
        if (dv16 !== 1'b1 || out16 !== exp) begin
            n_fail++;
            $display("FAIL wide_read0: valid=%b out=%h, expected 1 %h", dv16, out16, exp);
        end
        @(negedge clk);
        a16 = 6'd62;
        exp16_q.push_back(16'hFFFF);
        exp = exp16_q.pop_front();
        n_vec++;
        if (dv16 !== 1'b1 || out16 !== exp || err16 !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_read63: valid=%b out=%h err=%b, expected 1 %h 0", dv16, out16, err16, exp);
        end
        @(negedge clk);
        en16 = 1'b0;
        exp = exp16_q.pop_front();
        n_vec++;
        if (dv16 !== 1'b1 || out16 !== exp) begin
            n_fail++;
            $display("FAIL wide_read62: valid=%b out=%h, expected 1 %h", dv16, out16, exp);
        end
        if (busy16 !== 1'b0) bb++;
        @(negedge clk);
        n_vec++;
        if (dv16 !== 1'b0 || out16 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wide_hold: valid=%b out=%h, expected 0 ffff", dv16, out16);
        end
        n_vec++;
        if (bb != 0) begin
            n_fail++;
            $display("FAIL wide_busy: busy cycles=%0d, expected 0", bb);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en8 = 1'b0;  rw8 = 1'b0;  clr8 = 1'b0;  a8 = '0;  d8 = '0;
        en12 = 1'b0; rw12 = 1'b0; clr12 = 1'b0; a12 = '0; d12 = '0;
        en16 = 1'b0; rw16 = 1'b0; clr16 = 1'b0; a16 = '0; d16 = '0;
        test_reset();
        test_first_read();
        test_write_read();
        test_clear();
        test_addr_err();
        test_reset_mid_sweep();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
Parametrised single-port synchronous RAM, the next generation of the fixed 16x8 memory. The processor datapath uses it for program and data storage. It generalises data width, address width and depth. New relative to the fixed block: a registered read with a one-cycle valid strobe, a hardware clear-sweep state machine (automatic after reset and on request), a busy indication, and out-of-range address detection.

Parameters:
- DATA_WIDTH, 8, width of the data_bus_in and data_bus_out words.
- ADDR_WIDTH, 4, width of address_bus.
- DEPTH, 16, number of implemented words. Legal range is 1 to 2**ADDR_WIDTH.
- INIT_CLEAR, 1, when 1 the block performs a clear sweep after every reset release. When 0 it enters IDLE directly.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mem_enable  input  1  access request, sampled at the rising edge.
- read_write  input  1  1 = read, 0 = write.
- address_bus  input  ADDR_WIDTH  word address.
- data_bus_in  input  DATA_WIDTH  write data.
- clear  input  1  single-cycle request to start a clear sweep.
- data_bus_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  one-cycle pulse; data_bus_out was updated by a read.
- busy  output  1  high while a clear sweep is in progress.
- addr_err  output  1  one-cycle pulse; an accepted access had address_bus >= DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_bus_out = 0, data_valid = 0, addr_err = 0, sweep counter = 0.
  - State goes to CLEAR if INIT_CLEAR = 1, else IDLE; busy follows the state.
  - Array contents are not reset by rst_n itself.
- State machine has two states, IDLE and CLEAR. busy = (state == CLEAR), registered.
- CLEAR:
  - Each rising edge writes 0 to mem[cnt], then cnt increments.
  - The edge that writes cnt = DEPTH-1 moves the state to IDLE and resets cnt to 0.
  - busy is therefore high for exactly DEPTH cycles.
  - mem_enable and clear are ignored; an asserted clear does not restart the sweep.
  - data_valid and addr_err stay 0; data_bus_out holds.
- IDLE, evaluated at each rising edge in priority order:
  1. clear = 1: go to CLEAR. A simultaneous mem_enable access is dropped (no write, no read, no valid).
  2. mem_enable = 1 and address_bus >= DEPTH: no array access; addr_err = 1 for one cycle; data_bus_out holds; data_valid = 0.
  3. mem_enable = 1, read_write = 1: data_bus_out <= mem[address_bus]; data_valid = 1 for one cycle. Read latency is 1 edge.
  4. mem_enable = 1, read_write = 0: mem[address_bus] <= data_bus_in; data_valid = 0; data_bus_out holds.
  5. mem_enable = 0: no access; data_valid = 0; addr_err = 0; data_bus_out holds.
- A read on the edge after a write to the same address returns the newly written data.
- Back-to-back reads on consecutive edges give consecutive valid pulses (data_valid held high).
- Reset asserted mid-sweep aborts the sweep.
  - INIT_CLEAR = 1: the sweep restarts from address 0 after release.
  - INIT_CLEAR = 0: the block enters IDLE with a partially cleared array.
- Address compare is unsigned over the full ADDR_WIDTH. When DEPTH = 2**ADDR_WIDTH, addr_err never fires.
- No combinational path from any input to any output.

Test Plan:
1. Defaults, INIT_CLEAR = 1; release rst_n -> busy high for exactly 16 cycles, then low. A read of address 5 then returns 0x00 with data_valid high for one cycle, one edge after the request.
2. Write 0x0F to address 5, then read address 5 on the next edge -> data_bus_out = 0x0F, data_valid = 1 for one cycle. data_bus_out holds 0x0F afterwards while mem_enable = 0.
3. Write 0xA5 to address 3; pulse clear together with a write of 0x77 to address 4 -> busy for 16 cycles. After the sweep, reads of addresses 3 and 4 both return 0x00 (the write to 4 was dropped).
4. DEPTH = 12: read address 12 and write address 15 -> addr_err pulses once per access; data_valid = 0; data_bus_out unchanged; address 11 is still readable.
5. Assert rst_n low 6 cycles into a sweep, then release -> busy high for a further 16 full cycles.
6. DATA_WIDTH = 16, ADDR_WIDTH = 6, DEPTH = 64, INIT_CLEAR = 0 -> busy never asserts. Reads on consecutive edges of addresses 0, 63 and 62 (after writing 0xBEEF, 0x1234 and 0xFFFF to them) return those values, each one edge after its request.
